fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-005 SHALL have port imem_req_addr, output, 32, fetch byte address, always word-aligned.
REQ-006 SHALL have port imem_req_ready, input, 1, memory accepts the request.
REQ-007 SHALL have port imem_rsp_valid, input, 1, response data valid.
REQ-008 SHALL have port imem_rsp_data, input, 32, fetched instruction word.
REQ-009 SHALL have port PCSrc, input, 1, taken-branch redirect from the branch logic.
REQ-010 SHALL have port PCTarget, input, 32, redirect address.
REQ-011 SHALL have port instr_valid, output, 1, buffer head holds a valid instruction for decode.
REQ-012 SHALL have port instr, output, 32, head instruction, feeding the opcode/func3/func7 fields to decode.
REQ-013 SHALL have port instr_pc, output, 32, address of the head instruction.
REQ-014 SHALL have port instr_ready, input, 1, decode consumes the head instruction.

Function
REQ-015 SHALL hold a 32-bit PC register plus a 2-entry FIFO of {pc, instr} pairs with a count of 0..2.
REQ-016 SHALL use a three-state FSM with these states:
- FETCH: issuing requests.
- WAIT: one request outstanding.
- DROP: one outstanding response to be discarded.
REQ-017 SHALL, in FETCH, assert imem_req_valid when count<2, with imem_req_addr=PC; deassert it in WAIT and DROP.
REQ-018 SHALL, on a FETCH request handshake (valid&ready), latch the request PC, set PC<=PC+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0), and go to WAIT.
REQ-019 SHALL, on imem_rsp_valid in WAIT, push {latched PC, imem_rsp_data} and return to FETCH; at most one request is ever outstanding.
REQ-020 SHALL, on imem_rsp_valid in DROP, discard the data and return to FETCH.
REQ-021 SHALL ignore imem_rsp_valid while in FETCH.
REQ-022 SHALL drive instr_valid=(count!=0) and present the FIFO head on instr/instr_pc.
REQ-023 SHALL pop the head when instr_valid&instr_ready; a push and pop in the same cycle SHALL leave count unchanged.
REQ-024 SHALL, when PCSrc=1, redirect with priority over every other event in that cycle:
- PC<={PCTarget[31:2],2'b00};
- FIFO flushed to count=0, with no push that cycle;
- next state = DROP if in WAIT without a same-cycle response, or if in FETCH with a same-cycle request handshake;
- otherwise next state = FETCH.
REQ-025 SHALL drop the imem_req_valid for the redirect cycle so that it is not issued for the stale PC; the new target is requested from the next cycle.
REQ-026 SHALL achieve best-case latency of 2 cycles from request handshake to instr_valid when the response arrives the cycle after the handshake.

Reset
REQ-027 SHALL, while rst=1, force imem_req_valid=0 and instr_valid=0, and at the clock edge set PC=RESET_PC, state=FETCH, count=0 and the latched PC to 0.
REQ-028 SHALL, when reset is applied mid-request (WAIT or DROP), abandon the outstanding request; the environment guarantees no stale response after reset.
REQ-029 SHALL output imem_req_addr=RESET_PC in the first cycle after rst deasserts.

Verification
REQ-030 SHALL cover reset then straight-line fetch with ready=1 and 1-cycle response: addrs 0,4,8 requested; instr_pc 0,4,8 delivered in order with matching data.
REQ-031 SHALL cover back-pressure with instr_ready=0: exactly two instructions buffered (count=2); imem_req_valid stays 0 until one pop, then fetch resumes at PC 8.
REQ-032 SHALL cover PCSrc=1 with PCTarget=32'h0000_0103 while in WAIT: the pending response is dropped, FIFO emptied, next request addr=32'h0000_0100.
REQ-033 SHALL cover PCSrc coinciding with a push, and PCSrc coinciding with a request handshake: no stale instr_valid and DROP entered correctly.
REQ-034 SHALL cover PC=32'hFFFF_FFFC fetched: the next request addr is 32'h0000_0000.
REQ-035 SHALL cover rst asserted in WAIT: next cycle instr_valid=0, and the first post-reset addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding request engine feeding a
// two-entry {pc, instr} buffer towards decode, with branch redirect and flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] req_pc_reg;
    logic [1:0]  count_reg;
    logic        rd_ptr_reg;
    logic        wr_ptr_reg;
    logic [31:0] fifo_pc_reg    [2];
    logic [31:0] fifo_instr_reg [2];

    logic req_fire;
    logic push;
    logic pop;

    // The request is withheld during a redirect so the stale PC never issues.
    assign imem_req_valid = !rst && (state_reg == ST_FETCH) && (count_reg != 2'd2) && !PCSrc;
    assign imem_req_addr  = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid = !rst && (count_reg != 2'd0);
    assign instr       = fifo_instr_reg[rd_ptr_reg];
    assign instr_pc    = fifo_pc_reg[rd_ptr_reg];

    assign push = (state_reg == ST_WAIT) && imem_rsp_valid && !PCSrc;
    assign pop  = instr_valid && instr_ready;

    // Buffer storage carries no reset; validity is tracked by count_reg alone.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_pc_reg[wr_ptr_reg]    <= req_pc_reg;
            fifo_instr_reg[wr_ptr_reg] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_FETCH;
            pc_reg     <= {RESET_PC[31:2], 2'b00};
            req_pc_reg <= 32'h0000_0000;
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else if (PCSrc) begin
            pc_reg     <= {PCTarget[31:2], 2'b00};
            count_reg  <= 2'd0;
            wr_ptr_reg <= rd_ptr_reg;
            // A request still in flight must have its response swallowed.
            if (((state_reg == ST_WAIT) && !imem_rsp_valid) ||
                ((state_reg == ST_FETCH) && req_fire))
                state_reg <= ST_DROP;
            else
                state_reg <= ST_FETCH;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (req_fire) begin
                        req_pc_reg <= pc_reg;
                        pc_reg     <= pc_reg + 32'd4;
                        state_reg  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid)
                        state_reg <= ST_FETCH;
                end
                ST_DROP: begin
                    if (imem_rsp_valid)
                        state_reg <= ST_FETCH;
                end
                default: state_reg <= ST_FETCH;
            endcase

            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;

            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each task drives one scenario cycle by cycle
// and checks outputs one time unit after the rising edge.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .PCSrc          (PCSrc),
        .PCTarget       (PCTarget),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        PCSrc = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_req_ready = 1'b1;
        step();
        step();
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        rst = 1'b0;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL post_reset_req_valid: got %b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== RESET_PC) begin n_err++; $display("FAIL post_reset_addr: got %h want %h", imem_req_addr, RESET_PC); end
        $display("test_reset: done");
    endtask

    task automatic test_straight_line();
        logic [31:0] a;
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i) * 32'd4;
            n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== a) begin n_err++; $display("FAIL straight_req[%0d]: got v=%b a=%h want v=1 a=%h", i, imem_req_valid, imem_req_addr, a); end
            step();
            n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL straight_wait_valid[%0d]: got %b want 0", i, imem_req_valid); end
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(a);
            step();
            imem_rsp_valid = 1'b0;
            n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== a || instr !== mem_word(a)) begin n_err++; $display("FAIL straight_deliver[%0d]: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", i, instr_valid, instr_pc, instr, a, mem_word(a)); end
            $display("straight: pc=%h instr=%h", instr_pc, instr);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        instr_ready = 1'b0;
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h0);
        step();
        imem_rsp_valid = 1'b0;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_err++; $display("FAIL bp_second_req: got v=%b a=%h want v=1 a=00000004", imem_req_valid, imem_req_addr); end
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h4);
        step();
        imem_rsp_valid = 1'b0;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL bp_full_stall: got %b want 0", imem_req_valid); end
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_err++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=00000000", instr_valid, instr_pc); end
        step();
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL bp_still_stalled: got %b want 0", imem_req_valid); end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        n_cmp++; if (instr_pc !== 32'h4 || instr !== mem_word(32'h4)) begin n_err++; $display("FAIL bp_after_pop: got pc=%h i=%h want pc=00000004 i=%h", instr_pc, instr, mem_word(32'h4)); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin n_err++; $display("FAIL bp_resume: got v=%b a=%h want v=1 a=00000008", imem_req_valid, imem_req_addr); end
        $display("backpressure: resumed at %h", imem_req_addr);
    endtask

    task automatic test_redirect_wait();
        do_reset();
        instr_ready = 1'b0;
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h0);
        step();
        imem_rsp_valid = 1'b0;
        step();
        PCSrc = 1'b1; PCTarget = 32'h0000_0103;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rw_redirect_cycle_valid: got %b want 0", imem_req_valid); end
        step();
        PCSrc = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rw_flushed: got %b want 0", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rw_drop_valid: got %b want 0", imem_req_valid); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
        step();
        imem_rsp_valid = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rw_dropped_rsp: got %b want 0", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0100) begin n_err++; $display("FAIL rw_target: got v=%b a=%h want v=1 a=00000100", imem_req_valid, imem_req_addr); end
        $display("redirect_wait: next addr=%h", imem_req_addr);
    endtask

    task automatic test_redirect_push();
        do_reset();
        instr_ready = 1'b0;
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h0);
        PCSrc = 1'b1; PCTarget = 32'h0000_0200;
        step();
        imem_rsp_valid = 1'b0; PCSrc = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rp_no_stale: got %b want 0", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0200) begin n_err++; $display("FAIL rp_target: got v=%b a=%h want v=1 a=00000200", imem_req_valid, imem_req_addr); end
        $display("redirect_push: next addr=%h", imem_req_addr);
    endtask

    task automatic test_redirect_fetch();
        do_reset();
        instr_ready = 1'b0;
        PCSrc = 1'b1; PCTarget = 32'h0000_0304;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rf_suppressed: got %b want 0", imem_req_valid); end
        step();
        PCSrc = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD1_BAD1;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0304) begin n_err++; $display("FAIL rf_target: got v=%b a=%h want v=1 a=00000304", imem_req_valid, imem_req_addr); end
        step();
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rf_rsp_ignored: got %b want 0", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0304) begin n_err++; $display("FAIL rf_still_fetching: got v=%b a=%h want v=1 a=00000304", imem_req_valid, imem_req_addr); end
        $display("redirect_fetch: addr=%h", imem_req_addr);
    endtask

    task automatic test_wrap();
        do_reset();
        instr_ready = 1'b0;
        PCSrc = 1'b1; PCTarget = 32'hFFFF_FFFF;
        step();
        PCSrc = 1'b0;
        n_cmp++; if (imem_req_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_aligned: got %h want fffffffc", imem_req_addr); end
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'hFFFF_FFFC);
        step();
        imem_rsp_valid = 1'b0;
        n_cmp++; if (instr_pc !== 32'hFFFF_FFFC || instr !== mem_word(32'hFFFF_FFFC)) begin n_err++; $display("FAIL wrap_deliver: got pc=%h i=%h want pc=fffffffc i=%h", instr_pc, instr, mem_word(32'hFFFF_FFFC)); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next: got v=%b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr); end
        $display("wrap: next addr=%h", imem_req_addr);
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        instr_ready = 1'b0;
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h0);
        step();
        imem_rsp_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        n_cmp++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rstw_forced: got iv=%b rv=%b want 0 0", instr_valid, imem_req_valid); end
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rstw_instr_valid: got %b want 0", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin n_err++; $display("FAIL rstw_addr: got v=%b a=%h want v=1 a=%h", imem_req_valid, imem_req_addr, RESET_PC); end
        $display("reset_in_wait: addr=%h", imem_req_addr);
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_backpressure();
        test_redirect_wait();
        test_redirect_push();
        test_redirect_fetch();
        test_wrap();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
